bcd_elapsed_timer: RTL and testbench

//  Parametrised BCD elapsed-time counter for reaction measurement: start/stop/clear control,

---
 rtl/bcd_elapsed_timer_pkg.sv | 13 +
 rtl/bcd_elapsed_timer_digit.sv | 25 ++
 rtl/bcd_elapsed_timer.sv | 131 +++++++++++++
 tb/tb_bcd_elapsed_timer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_elapsed_timer_pkg.sv
// Shared constants and state encoding for the BCD elapsed-time counter.
package timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2,
        LATE    = 2'd3
    } tstate_t;

endpackage

// File: rtl/bcd_elapsed_timer_digit.sv
// One decimal digit of the cascaded counter; carry fires when it rolls 9 -> 0.
module bcd_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/bcd_elapsed_timer.sv
// Start/stop BCD elapsed timer with prescaler, captured result, late flag and best time.
// Handshake: start/stop are single-cycle pulses; done is a single-cycle pulse after capture.
module bcd_elapsed_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    stop,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [4*NUM_DIGITS-1:0] result,
    output logic [4*NUM_DIGITS-1:0] best,
    output logic                    best_valid,
    output logic                    done,
    output logic                    running,
    output logic                    time_late
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    tstate_t               state;
    tstate_t               state_next;
    logic [PW-1:0]         presc;
    logic                  tick;
    logic                  start_acc;
    logic                  stop_acc;
    logic                  cnt_en;
    logic                  digit_clr;
    logic                  all9;
    logic                  overflow;
    logic                  late_entry;
    logic [NUM_DIGITS-1:0] is9;
    logic [NUM_DIGITS:0]   carry;

    assign start_acc = start && (state != RUN);
    assign stop_acc  = stop && (state == RUN);
    assign tick      = ((state == RUN) || (state == LATE)) && (presc == PRESC_LAST);
    assign all9      = &is9;
    assign digit_clr = clr || start_acc;

    // The stop edge never advances the count, so the held count always equals result.
    assign cnt_en = tick
                 && (((state == RUN) && !stop) || ((state == LATE) && !SATURATE))
                 && !(SATURATE && all9);

    // With wrapping, the chain's carry-out is exactly the overflow event.
    assign overflow   = SATURATE ? (tick && all9) : carry[NUM_DIGITS];
    assign late_entry = overflow && (state == RUN) && !stop;

    assign carry[0] = cnt_en;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (digit_clr),
            .en    (carry[g]),
            .q     (count[4*g +: 4]),
            .carry (carry[g+1])
        );
        assign is9[g] = (count[4*g +: 4] == BCD_MAX);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, STOPPED: if (start) state_next = RUN;
            RUN: begin
                if (stop)            state_next = STOPPED;
                else if (late_entry) state_next = LATE;
            end
            LATE:          if (start) state_next = RUN;
            default:       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr || start_acc) begin
            presc <= '0;
        end else if ((state == RUN) || (state == LATE)) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr || start_acc) begin
            time_late <= 1'b0;
        end else if (late_entry) begin
            time_late <= 1'b1;
        end
    end

    // Packed BCD orders the same as its decimal value, so a plain unsigned compare works.
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            best       <= '0;
            best_valid <= 1'b0;
            done       <= 1'b0;
        end else if (clr) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= stop_acc;
            if (stop_acc) begin
                result <= count;
                if (!best_valid || (count < best)) begin
                    best       <= count;
                    best_valid <= 1'b1;
                end
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_elapsed_timer.sv
// Directed bench for bcd_elapsed_timer: saturating and wrapping instances share one stimulus stream.
module tb_bcd_elapsed_timer;

    localparam int ND = 2;
    localparam int TD = 2;
    localparam int W  = 4 * ND;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;

    logic [W-1:0] count_s, result_s, best_s, count_w, result_w, best_w;
    logic best_valid_s, done_s, running_s, time_late_s;
    logic best_valid_w, done_w, running_w, time_late_w;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    bcd_elapsed_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop),
        .count(count_s), .result(result_s), .best(best_s), .best_valid(best_valid_s),
        .done(done_s), .running(running_s), .time_late(time_late_s)
    );

    bcd_elapsed_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop),
        .count(count_w), .result(result_w), .best(best_w), .best_valid(best_valid_w),
        .done(done_w), .running(running_w), .time_late(time_late_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((n / 10) % 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    // One clock: drive controls, sample #1 after the edge, score any done pulse.
    task automatic step(input logic s, input logic p, input logic c, input logic r);
        start = s; stop = p; clr = c; rst = r;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clr = 1'b0; rst = 1'b0;
        if (done_s) begin
            if (exp_q.size() == 0) check("done_unexpected", 32'(done_s), 32'd0);
            else                   check("result_on_done", 32'(result_s), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic timed_run(input int ticks);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(ticks * TD);
        check("run_count", 32'(count_s), 32'(to_bcd(ticks)));
        exp_q.push_back(to_bcd(ticks));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_done_hi", 32'(done_s), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("run_done_lo", 32'(done_s), 32'd0);
    endtask

    initial begin
        // reset
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count_s), 32'd0);
        check("rst_result", 32'(result_s), 32'd0);
        check("rst_best", 32'(best_s), 32'd0);
        check("rst_best_valid", 32'(best_valid_s), 32'd0);
        check("rst_done", 32'(done_s), 32'd0);
        check("rst_running", 32'(running_s), 32'd0);
        check("rst_time_late", 32'(time_late_s), 32'd0);
        check("rst_count_w", 32'(count_w), 32'd0);

        // single 74-cycle measurement
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_running", 32'(running_s), 32'd1);
        check("t2_count0", 32'(count_s), 32'd0);
        idle(74);
        check("t2_count", 32'(count_s), 32'h37);
        exp_q.push_back(8'h37);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_done", 32'(done_s), 32'd1);
        check("t2_result", 32'(result_s), 32'h37);
        check("t2_best", 32'(best_s), 32'h37);
        check("t2_best_valid", 32'(best_valid_s), 32'd1);
        check("t2_running_off", 32'(running_s), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_done_lo", 32'(done_s), 32'd0);
        check("t2_count_hold", 32'(count_s), 32'h37);

        // best tracking over two runs
        timed_run(25);
        check("t3_best_a", 32'(best_s), 32'h25);
        timed_run(40);
        check("t3_result", 32'(result_s), 32'h40);
        check("t3_best", 32'(best_s), 32'h25);
        check("t3_best_w", 32'(best_w), 32'h25);

        // overflow: saturating vs wrapping
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(99 * TD);
        check("t4_s_99", 32'(count_s), 32'h99);
        check("t4_w_99", 32'(count_w), 32'h99);
        check("t4_late_pre", 32'(time_late_s), 32'd0);
        idle(TD);
        check("t4_s_sat", 32'(count_s), 32'h99);
        check("t4_w_wrap", 32'(count_w), 32'h00);
        check("t4_s_late", 32'(time_late_s), 32'd1);
        check("t4_w_late", 32'(time_late_w), 32'd1);
        check("t4_s_running", 32'(running_s), 32'd0);
        idle(TD);
        check("t4_w_next", 32'(count_w), 32'h01);
        check("t4_s_hold", 32'(count_s), 32'h99);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_stop_done_s", 32'(done_s), 32'd0);
        check("t4_stop_done_w", 32'(done_w), 32'd0);
        check("t4_result_s", 32'(result_s), 32'h40);
        check("t4_result_w", 32'(result_w), 32'h40);

        // restart from LATE, then clr at tick 12
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_late_cleared", 32'(time_late_s), 32'd0);
        check("t5_running", 32'(running_s), 32'd1);
        idle(12 * TD);
        check("t5_count12", 32'(count_s), 32'h12);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_clr_count", 32'(count_s), 32'd0);
        check("t5_clr_running", 32'(running_s), 32'd0);
        check("t5_clr_late", 32'(time_late_s), 32'd0);
        check("t5_clr_result", 32'(result_s), 32'd0);
        check("t5_clr_best", 32'(best_s), 32'h25);
        check("t5_clr_best_valid", 32'(best_valid_s), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_rst_best_valid", 32'(best_valid_s), 32'd0);
        check("t5_rst_best", 32'(best_s), 32'd0);

        // simultaneous start+stop
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_idle_pair_run", 32'(running_s), 32'd1);
        check("t6_idle_pair_done", 32'(done_s), 32'd0);
        idle(6);
        check("t6_count3", 32'(count_s), 32'h03);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_start_ignored_cnt", 32'(count_s), 32'h03);
        check("t6_start_ignored_run", 32'(running_s), 32'd1);
        exp_q.push_back(8'h03);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_run_pair_done", 32'(done_s), 32'd1);
        check("t6_run_pair_running", 32'(running_s), 32'd0);
        check("t6_result", 32'(result_s), 32'h03);
        check("t6_best", 32'(best_s), 32'h03);
        check("t6_best_valid", 32'(best_valid_s), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_count_hold", 32'(count_s), 32'h03);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
